// File: rtl/kgp_ctrl_pkg.sv
// Shared encodings for the KGP-RISC multi-cycle control unit:
// FSM states, opcode classes, ALU/source/branch codes and the decoded control bundle.
package kgp_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_MEM     = 3'd4,
    ST_MEMWAIT = 3'd5,
    ST_WB      = 3'd6,
    ST_HALT    = 3'd7
  } state_t;

  // Opcode classes; every other opcode value is undefined
  localparam logic [4:0] OP_ALU   = 5'd0;
  localparam logic [4:0] OP_ALUI  = 5'd1;
  localparam logic [4:0] OP_SHIFT = 5'd2;
  localparam logic [4:0] OP_LD    = 5'd3;
  localparam logic [4:0] OP_ST    = 5'd4;
  localparam logic [4:0] OP_BR    = 5'd5;
  localparam logic [4:0] OP_BRL   = 5'd6;
  localparam logic [4:0] OP_BCOND = 5'd7;
  localparam logic [4:0] OP_HALT  = 5'd31;

  // ALUResOp codes
  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_AND   = 3'd1;
  localparam logic [2:0] ALU_XOR   = 3'd2;
  localparam logic [2:0] ALU_SHIFT = 3'd3;
  localparam logic [2:0] ALU_COMP  = 3'd4;
  localparam logic [2:0] ALU_SHRA  = 3'd5;

  // ALUSrc codes
  localparam logic [1:0] SRC_RT    = 2'd0;
  localparam logic [1:0] SRC_IMM   = 2'd1;
  localparam logic [1:0] SRC_SHAMT = 2'd2;

  // Branch class codes for the next-PC logic
  localparam logic [2:0] BR_NONE   = 3'd0;
  localparam logic [2:0] BR_UNCOND = 3'd1;
  localparam logic [2:0] BR_LTZ    = 3'd2;
  localparam logic [2:0] BR_Z      = 3'd3;
  localparam logic [2:0] BR_NZ     = 3'd4;
  localparam logic [2:0] BR_CY     = 3'd5;
  localparam logic [2:0] BR_NCY    = 3'd6;

  // Decoded control bundle: level controls plus the class flags the FSM needs
  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_cin;
    logic       alu_dir;
    logic       alu_frc;
    logic [1:0] alu_src;
    logic [2:0] branch;
    logic       br_link;
    logic       mem_to_reg;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic       is_halt;
  } ctl_t;

  localparam ctl_t CTL_NOP = ctl_t'(17'd0);

endpackage

// File: rtl/kgp_ctrl_decode.sv
// Combinational instruction decoder: opcode/funccode to control bundle plus
// an undefined-encoding flag. Registered by the sequencer in DECODE.
module kgp_ctrl_decode
  import kgp_ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  input  logic [4:0] funccode,
  output ctl_t       ctl,
  output logic       illegal
);

  // Map each opcode class (and function field where relevant) to its controls
  always_comb begin
    ctl     = CTL_NOP;
    illegal = 1'b0;
    case (opcode)
      OP_ALU: begin
        ctl.alu_frc = 1'b1;
        ctl.alu_src = SRC_RT;
        ctl.reg_wr  = 1'b1;
        case (funccode)
          5'd0: ctl.alu_op = ALU_ADD;
          5'd1: begin
            ctl.alu_op  = ALU_COMP;
            ctl.alu_cin = 1'b1;
          end
          5'd2: ctl.alu_op = ALU_AND;
          5'd3: ctl.alu_op = ALU_XOR;
          default: illegal = 1'b1;
        endcase
      end
      OP_ALUI: begin
        ctl.alu_frc = 1'b1;
        ctl.alu_src = SRC_IMM;
        ctl.reg_wr  = 1'b1;
        case (funccode)
          5'd0: ctl.alu_op = ALU_ADD;
          5'd1: begin
            ctl.alu_op  = ALU_COMP;
            ctl.alu_cin = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_SHIFT: begin
        ctl.alu_frc = 1'b1;
        ctl.alu_op  = ALU_SHIFT;
        ctl.reg_wr  = 1'b1;
        case (funccode)
          5'd0: begin
            ctl.alu_dir = 1'b1;
            ctl.alu_src = SRC_SHAMT;
          end
          5'd1: ctl.alu_src = SRC_SHAMT;
          5'd2: begin
            ctl.alu_op  = ALU_SHRA;
            ctl.alu_src = SRC_SHAMT;
          end
          5'd3: begin
            ctl.alu_dir = 1'b1;
            ctl.alu_src = SRC_RT;
          end
          5'd4: ctl.alu_src = SRC_RT;
          5'd5: begin
            ctl.alu_op  = ALU_SHRA;
            ctl.alu_src = SRC_RT;
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_LD: begin
        ctl.alu_op     = ALU_ADD;
        ctl.alu_src    = SRC_IMM;
        ctl.mem_to_reg = 1'b1;
        ctl.mem_rd     = 1'b1;
        ctl.reg_wr     = 1'b1;
      end
      OP_ST: begin
        ctl.alu_op  = ALU_ADD;
        ctl.alu_src = SRC_IMM;
        ctl.mem_wr  = 1'b1;
      end
      OP_BR: ctl.branch = BR_UNCOND;
      OP_BRL: begin
        ctl.branch  = BR_UNCOND;
        ctl.br_link = 1'b1;
        ctl.reg_wr  = 1'b1;
      end
      OP_BCOND: begin
        case (funccode)
          5'd0: ctl.branch = BR_LTZ;
          5'd1: ctl.branch = BR_Z;
          5'd2: ctl.branch = BR_NZ;
          5'd3: ctl.branch = BR_CY;
          5'd4: ctl.branch = BR_NCY;
          default: illegal = 1'b1;
        endcase
      end
      OP_HALT: ctl.is_halt = 1'b1;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/kgp_ctrl_sequencer.sv
// Multi-cycle KGP-RISC control unit: owns the PC, walks each instruction through
// fetch/decode/execute/memory/writeback and drives registered datapath controls.
module kgp_ctrl_sequencer
  import kgp_ctrl_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0,
  parameter int          IMEM_LAT = 1,
  parameter int          DMEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  opcode,
  input  logic [4:0]  funccode,
  input  logic [31:0] nextInstrAddr,
  output logic [31:0] instrAddr,
  output logic [2:0]  ALUResOp,
  output logic        ALUCin,
  output logic        ALUDir,
  output logic        ALUFrc,
  output logic [1:0]  ALUSrc,
  output logic [2:0]  branch,
  output logic        brLink,
  output logic        memToReg,
  output logic        memRead,
  output logic        memWrite,
  output logic        regWrite,
  output logic        busy,
  output logic        halted,
  output logic        illegal,
  output logic [31:0] instr_count
);

  // FETCH spends IMEM_LAT cycles beyond address issue; MEMWAIT spans DMEM_LAT cycles
  localparam logic [7:0] IMEM_LAST = 8'(IMEM_LAT);
  localparam logic [7:0] DMEM_LAST = 8'(DMEM_LAT - 1);

  state_t      state_r, state_nxt_s;
  logic [7:0]  cnt_r, cnt_nxt_s;
  ctl_t        ctl_r, ctl_nxt_s;
  logic [31:0] pc_r, pc_nxt_s;
  logic [31:0] count_r, count_nxt_s;
  logic        illegal_r, illegal_nxt_s;
  ctl_t        dec_ctl_s;
  logic        dec_illegal_s;
  logic        lv_on_s;

  kgp_ctrl_decode u_decode (
    .opcode   (opcode),
    .funccode (funccode),
    .ctl      (dec_ctl_s),
    .illegal  (dec_illegal_s)
  );

  assign instrAddr   = pc_r;
  assign instr_count = count_r;
  assign illegal     = illegal_r;

  // State, wait counter and latched control bundle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 8'd0;
      ctl_r   <= CTL_NOP;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      ctl_r   <= ctl_nxt_s;
    end
  end

  // Next-state, PC, retire count and sticky illegal flag
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = 8'd0;
    ctl_nxt_s     = ctl_r;
    pc_nxt_s      = pc_r;
    count_nxt_s   = count_r;
    illegal_nxt_s = illegal_r;
    case (state_r)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          pc_nxt_s      = PC_RESET;
          count_nxt_s   = 32'd0;
          illegal_nxt_s = 1'b0;
          state_nxt_s   = ST_FETCH;
        end else begin
          state_nxt_s   = state_r;
        end
      end
      ST_FETCH: begin
        if (cnt_r == IMEM_LAST) begin
          state_nxt_s = ST_DECODE;
        end else begin
          cnt_nxt_s   = cnt_r + 8'd1;
        end
      end
      ST_DECODE: begin
        ctl_nxt_s = dec_ctl_s;
        if (dec_illegal_s) begin
          illegal_nxt_s = 1'b1;
          state_nxt_s   = ST_HALT;
        end else if (dec_ctl_s.is_halt) begin
          count_nxt_s   = count_r + 32'd1;
          state_nxt_s   = ST_HALT;
        end else begin
          state_nxt_s   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (ctl_r.mem_rd || ctl_r.mem_wr) begin
          state_nxt_s = ST_MEM;
        end else begin
          state_nxt_s = ST_WB;
        end
      end
      ST_MEM: begin
        if (ctl_r.mem_rd) begin
          state_nxt_s = ST_MEMWAIT;
        end else begin
          state_nxt_s = ST_WB;
        end
      end
      ST_MEMWAIT: begin
        if (cnt_r == DMEM_LAST) begin
          state_nxt_s = ST_WB;
        end else begin
          cnt_nxt_s   = cnt_r + 8'd1;
        end
      end
      ST_WB: begin
        pc_nxt_s    = nextInstrAddr;
        count_nxt_s = count_r + 32'd1;
        state_nxt_s = ST_FETCH;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Level controls are live only from EXEC through WB
  assign lv_on_s = (state_nxt_s == ST_EXEC) || (state_nxt_s == ST_MEM) ||
                   (state_nxt_s == ST_MEMWAIT) || (state_nxt_s == ST_WB);

  // Registered architectural state and datapath controls, computed from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_r      <= PC_RESET;
      count_r   <= 32'd0;
      illegal_r <= 1'b0;
      ALUResOp  <= 3'd0;
      ALUCin    <= 1'b0;
      ALUDir    <= 1'b0;
      ALUFrc    <= 1'b0;
      ALUSrc    <= 2'd0;
      branch    <= 3'd0;
      brLink    <= 1'b0;
      memToReg  <= 1'b0;
      memRead   <= 1'b0;
      memWrite  <= 1'b0;
      regWrite  <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
    end else begin
      pc_r      <= pc_nxt_s;
      count_r   <= count_nxt_s;
      illegal_r <= illegal_nxt_s;
      ALUResOp  <= lv_on_s ? ctl_nxt_s.alu_op     : 3'd0;
      ALUCin    <= lv_on_s ? ctl_nxt_s.alu_cin    : 1'b0;
      ALUDir    <= lv_on_s ? ctl_nxt_s.alu_dir    : 1'b0;
      ALUFrc    <= lv_on_s ? ctl_nxt_s.alu_frc    : 1'b0;
      ALUSrc    <= lv_on_s ? ctl_nxt_s.alu_src    : 2'd0;
      branch    <= lv_on_s ? ctl_nxt_s.branch     : 3'd0;
      brLink    <= lv_on_s ? ctl_nxt_s.br_link    : 1'b0;
      memToReg  <= lv_on_s ? ctl_nxt_s.mem_to_reg : 1'b0;
      memRead   <= ctl_nxt_s.mem_rd && ((state_nxt_s == ST_MEM) || (state_nxt_s == ST_MEMWAIT));
      memWrite  <= ctl_nxt_s.mem_wr && (state_nxt_s == ST_MEM);
      regWrite  <= ctl_nxt_s.reg_wr && (state_nxt_s == ST_WB);
      busy      <= (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_HALT);
      halted    <= (state_nxt_s == ST_HALT);
    end
  end

endmodule

// File: doc/kgp_ctrl_sequencer.md
Name: kgp_ctrl_sequencer

Overview:
- Multi-cycle control unit for the KGP-RISC datapath.
- Owns the program counter and drives instrAddr into the datapath.
- Reads back opcode/funccode/nextInstrAddr, then walks each instruction through fetch, decode, execute, memory and writeback.
- Generates every datapath control line, and accounts for synchronous BRAM read latency on both instruction and data memory.

Parameters:
PC_RESET, 32'h0, PC value loaded on reset and on start
IMEM_LAT, 1, instruction BRAM read latency in cycles (>=1)
DMEM_LAT, 1, data BRAM read latency in cycles (>=1)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  pulse: leave IDLE/HALT, PC<=PC_RESET, begin fetch
opcode  in  5  instruction opcode from datapath
funccode  in  5  function field from datapath
nextInstrAddr  in  32  resolved next PC from datapath
instrAddr  out  32  current PC to datapath
ALUResOp  out  3  ALU operation select
ALUCin  out  1  ALU carry-in
ALUDir  out  1  shift direction (1=left)
ALUFrc  out  1  selects RS and I-type immediate (0 selects RT and LS immediate)
ALUSrc  out  2  0=RT, 1=sign-extended imm, 2=shamt
branch  out  3  branch class to next-PC logic
brLink  out  1  link-register write select
memToReg  out  1  writeback from memory
memRead  out  1  data read enable
memWrite  out  1  data write strobe
regWrite  out  1  register write strobe
busy  out  1  high outside IDLE/HALT
halted  out  1  high in HALT
illegal  out  1  sticky: halt caused by undefined opcode/funccode
instr_count  out  32  retired instructions since start

Behaviour:
- Reset (async, rst=0):
  - State IDLE; instrAddr=PC_RESET.
  - All control outputs 0; busy=halted=illegal=0; instr_count=0.
  - Takes effect immediately mid-instruction. Any pending memWrite/regWrite is dropped, never completed.
- States: IDLE, FETCH, DECODE, EXEC, MEM, MEMWAIT, WB, HALT.
- IDLE or HALT + start=1: PC<=PC_RESET, clear illegal and instr_count, go to FETCH. Otherwise start is ignored.
- FETCH: wait-state counter holds for IMEM_LAT cycles with instrAddr stable, then go to DECODE.
- DECODE:
  - Latch opcode/funccode.
  - Drive the decoded level controls (ALUResOp, ALUCin, ALUDir, ALUFrc, ALUSrc, branch, brLink, memToReg). They stay constant through WB.
  - Undefined encoding: illegal<=1, go to HALT. HALT opcode: go to HALT, retiring the instruction.
- EXEC: one cycle for ALU/flags to settle. Go to MEM for load/store, else WB.
- MEM:
  - Load: memRead=1 held through MEMWAIT; MEMWAIT lasts DMEM_LAT cycles.
  - Store: memWrite=1 for exactly one cycle, then WB.
- WB:
  - regWrite=1 for exactly one cycle for ALU/shift/load/link-branch.
  - instrAddr<=nextInstrAddr on the WB clock edge; instr_count+=1 (wraps at 2^32).
  - Go to FETCH.
- Latency at IMEM_LAT=DMEM_LAT=1:
  - ALU/branch: 5 cycles.
  - Store: 6 cycles.
  - Load: 7 cycles.
- Strobes:
  - memWrite and regWrite are never high together, and never high outside MEM/WB respectively.
  - Level controls are 0 in IDLE/HALT/FETCH.
- HALT: busy=0, halted=1, PC frozen; only start or rst exits.
- PC arithmetic: 32-bit; overflow wraps; no alignment checks.

Decomposition:
- Package kgp_ctrl_pkg holds:
  - state enum;
  - opcode class constants (OP_ALU, OP_ALUI, OP_SHIFT, OP_LD, OP_ST, OP_BR, OP_BRL, OP_BCOND, OP_HALT);
  - ALUResOp codes;
  - ALUSrc codes;
  - branch class codes.
- Sub-module kgp_ctrl_decode: purely combinational opcode/funccode to control bundle plus illegal flag. The FSM registers its output in DECODE.

Test Plan:
- Reset mid-WB of ADD at PC=0x8 -> regWrite drops the same cycle; instrAddr=0x0; state IDLE; instr_count=0.
- start, ADD at 0x0, nextInstrAddr=0x4 -> regWrite pulses once in cycle 5; instrAddr=0x4 afterwards; instr_count=1.
- Store at 0x4 -> memWrite high exactly 1 cycle (cycle 5), regWrite never asserted; 6 cycles to next FETCH.
- Load, DMEM_LAT=2 -> memRead high 3 cycles, memToReg=1 during WB, regWrite single pulse; 8 cycles total.
- Branch-and-link with nextInstrAddr=0x40 -> brLink=1, regWrite pulse in WB, instrAddr=0x40.
- Undefined opcode 5'b10110 -> HALT; illegal=1, halted=1, busy=0, PC frozen, instr_count unchanged. start restarts from PC_RESET with illegal cleared.
